// File: rtl/core_pkg.sv
// Types and constants shared by the writeback path: register index width,
// datapath width and the buffered long-latency result entry.
package core_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      dat;
  } wb_entry_t;

  // x0 is hardwired to zero, so it never gets written and never goes busy.
  function automatic logic is_real_reg(input logic [REG_IDX_W-1:0] idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries with a combinational head view,
// so the arbiter can pick the oldest long-latency result in the same cycle.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_data,
  input  logic                     pop,
  output wb_entry_t                pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  wb_entry_t              mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W:0]         count_reg;
  logic [PTR_W:0]         count_next;

  // Storage carries no reset: stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign full     = (count_reg == DEPTH_CNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU and long-latency results onto the single
// register-file write port and tracks busy registers for decode hazard checks.
module writeback_unit
  import core_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = core_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid_i,
  input  logic [4:0]           alu_rd_i,
  input  logic [XLEN-1:0]      alu_dat_i,
  output logic                 alu_stall_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_rd_i,
  input  logic [XLEN-1:0]      lsu_dat_i,
  output logic                 lsu_ready_o,
  input  logic                 issue_long_i,
  input  logic [4:0]           issue_rd_i,
  input  logic [4:0]           chk_rs1_i,
  input  logic [4:0]           chk_rs2_i,
  input  logic [4:0]           chk_rd_i,
  output logic                 hazard_o,
  output logic [4:0]           reg_des_o,
  output logic [XLEN-1:0]      reg_des_dat_o,
  output logic                 wr_en_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t         push_entry;
  wb_entry_t         head_entry;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic              sel_alu;
  logic [4:0]        reg_des_reg,  reg_des_next;
  logic [XLEN-1:0]   dat_reg,      dat_next;
  logic              wr_en_reg,    wr_en_next;
  logic              wb_long_reg,  wb_long_next;
  logic              load_out;
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  assign push_entry = '{rd: lsu_rd_i, dat: lsu_dat_i};

  // Ready looks only at occupancy, never at a same-cycle pop, to keep the
  // handshake free of a combinational path through the arbiter.
  assign lsu_ready_o = !fifo_full;
  assign fifo_push   = lsu_valid_i && !fifo_full;

  // A full buffer takes priority so long results cannot starve behind a
  // continuous ALU stream.
  assign sel_alu     = alu_valid_i && !fifo_full;
  assign fifo_pop    = fifo_full || (!alu_valid_i && !fifo_empty);
  assign alu_stall_o = alu_valid_i && fifo_full;
  assign load_out    = sel_alu || fifo_pop;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    reg_des_next = reg_des_reg;
    dat_next     = dat_reg;
    wr_en_next   = 1'b0;
    wb_long_next = 1'b0;
    if (sel_alu) begin
      reg_des_next = alu_rd_i;
      dat_next     = alu_dat_i;
      wr_en_next   = is_real_reg(alu_rd_i);
    end else if (fifo_pop) begin
      reg_des_next = head_entry.rd;
      dat_next     = head_entry.dat;
      wr_en_next   = is_real_reg(head_entry.rd);
      wb_long_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_des_reg <= '0;
      dat_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wb_long_reg <= 1'b0;
    end else begin
      if (load_out) begin
        reg_des_reg <= reg_des_next;
        dat_reg     <= dat_next;
      end
      wr_en_reg   <= wr_en_next;
      wb_long_reg <= wb_long_next;
    end
  end

  // Busy clears only on the commit edge of a long writeback; a new issue to
  // the same register on that edge keeps the bit set.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_next[gi] = 1'b0;
      end else begin : g_rn
        logic set_bit;
        logic clr_bit;
        assign set_bit = issue_long_i && (issue_rd_i == REG_IDX_W'(gi));
        assign clr_bit = wb_long_reg && (reg_des_reg == REG_IDX_W'(gi));
        assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign hazard_o      = busy_reg[chk_rs1_i] | busy_reg[chk_rs2_i] | busy_reg[chk_rd_i];
  assign reg_des_o     = reg_des_reg;
  assign reg_des_dat_o = dat_reg;
  assign wr_en_o       = wr_en_reg;

endmodule
